// File: rtl/dmem_unit.sv
// Data memory for a 64-bit core: zero-latency RAM loads plus a small MMIO page
// (TOHOST, CYCLE, STATUS) and a sticky misaligned-access flag.
module dmem_unit #(
    parameter int          DEPTH     = 1024,
    parameter logic [63:0] MMIO_BASE = 64'h0000_0000_1000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] addr,
    input  logic [63:0] writeData,
    input  logic        memWrite,
    input  logic [2:0]  memType,
    output logic [63:0] readData,
    output logic        misaligned,
    output logic [63:0] misalignedAddr,
    output logic [63:0] toHost,
    output logic        toHostValid
);
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [63:0] RAM_BYTES = 64'(DEPTH) << 3;

    logic [63:0] mem [DEPTH];

    logic        misaligned_q, misaligned_d;
    logic [63:0] misalignedAddr_q, misalignedAddr_d;
    logic [63:0] toHost_q, toHost_d;
    logic        toHostValid_q, toHostValid_d;
    logic [63:0] cycle_q, cycle_d;

    logic [1:0]    size;
    logic          reserved;
    logic          misal_raw;
    logic          misal;
    logic          valid_acc;
    logic          in_ram;
    logic          in_mmio;
    logic [AW-1:0] word_idx;
    logic [5:0]    shamt;
    logic [8:0]    mmio_word;
    logic [63:0]   raw_word;
    logic [63:0]   lane;
    logic [63:0]   size_mask;
    logic [63:0]   wmask;
    logic [63:0]   wdata_sh;
    logic          ram_we;
    logic          tohost_we;
    logic          status_clr;

    assign size      = memType[1:0];
    assign reserved  = (memType == 3'b111);
    assign in_ram    = (addr < RAM_BYTES);
    assign in_mmio   = (addr[63:12] == MMIO_BASE[63:12]);
    assign word_idx  = addr[AW+2:3];
    assign shamt     = {addr[2:0], 3'b000};
    assign mmio_word = addr[11:3];

    always_comb begin
        misal_raw = 1'b0;
        case (size)
            2'b00:   misal_raw = 1'b0;
            2'b01:   misal_raw = addr[0];
            2'b10:   misal_raw = |addr[1:0];
            default: misal_raw = |addr[2:0];
        endcase
    end

    // The reserved encoding is neither a valid access nor a misaligned one.
    assign misal     = misal_raw && !reserved;
    assign valid_acc = !misal_raw && !reserved;

    always_comb begin
        raw_word = '0;
        if (in_ram) begin
            raw_word = mem[word_idx];
        end else if (in_mmio) begin
            case (mmio_word)
                9'd0:    raw_word = toHost_q;
                9'd1:    raw_word = cycle_q;
                9'd2:    raw_word = {63'b0, misaligned_q};
                default: raw_word = '0;
            endcase
        end
    end

    assign lane = raw_word >> shamt;

    always_comb begin
        readData = '0;
        if (valid_acc) begin
            case (memType)
                3'b000:  readData = {{56{lane[7]}}, lane[7:0]};
                3'b001:  readData = {{48{lane[15]}}, lane[15:0]};
                3'b010:  readData = {{32{lane[31]}}, lane[31:0]};
                3'b011:  readData = lane;
                3'b100:  readData = {56'b0, lane[7:0]};
                3'b101:  readData = {48'b0, lane[15:0]};
                3'b110:  readData = {32'b0, lane[31:0]};
                default: readData = '0;
            endcase
        end
    end

    always_comb begin
        size_mask = '1;
        case (size)
            2'b00:   size_mask = 64'h0000_0000_0000_00FF;
            2'b01:   size_mask = 64'h0000_0000_0000_FFFF;
            2'b10:   size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = '1;
        endcase
    end

    assign wmask      = size_mask << shamt;
    assign wdata_sh   = writeData << shamt;
    assign ram_we     = reset && memWrite && valid_acc && in_ram;
    assign tohost_we  = memWrite && valid_acc && !in_ram && in_mmio &&
                        (mmio_word == 9'd0) && (size == 2'b11);
    assign status_clr = memWrite && valid_acc && !in_ram && in_mmio &&
                        (mmio_word == 9'd2);

    // RAM has no reset; the write enable already excludes edges with reset low.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[word_idx] <= (mem[word_idx] & ~wmask) | (wdata_sh & wmask);
        end
    end

    always_comb begin
        cycle_d          = cycle_q + 64'd1;
        toHostValid_d    = tohost_we;
        toHost_d         = tohost_we ? writeData : toHost_q;
        misaligned_d     = misaligned_q;
        misalignedAddr_d = misalignedAddr_q;
        // A new misaligned access wins over a STATUS clear in the same cycle.
        if (misal) begin
            misaligned_d = 1'b1;
            if (!misaligned_q) begin
                misalignedAddr_d = addr;
            end
        end else if (status_clr) begin
            misaligned_d     = 1'b0;
            misalignedAddr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_q          <= '0;
            toHost_q         <= '0;
            toHostValid_q    <= 1'b0;
            misaligned_q     <= 1'b0;
            misalignedAddr_q <= '0;
        end else begin
            cycle_q          <= cycle_d;
            toHost_q         <= toHost_d;
            toHostValid_q    <= toHostValid_d;
            misaligned_q     <= misaligned_d;
            misalignedAddr_q <= misalignedAddr_d;
        end
    end

    assign misaligned     = misaligned_q;
    assign misalignedAddr = misalignedAddr_q;
    assign toHost         = toHost_q;
    assign toHostValid    = toHostValid_q;
endmodule

// File: tb/tb_dmem_unit.sv
// Directed bench for dmem_unit: RAM load/store lanes, misalignment flag,
// MMIO TOHOST/CYCLE/STATUS, unmapped accesses and reset behaviour.
module tb_dmem_unit;
    localparam logic [63:0] MB = 64'h0000_0000_1000_0000;

    logic        clk;
    logic        reset;
    logic [63:0] addr;
    logic [63:0] writeData;
    logic        memWrite;
    logic [2:0]  memType;
    logic [63:0] readData;
    logic        misaligned;
    logic [63:0] misalignedAddr;
    logic [63:0] toHost;
    logic        toHostValid;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_unit #(.DEPTH(1024), .MMIO_BASE(MB)) dut (
        .clk            (clk),
        .reset          (reset),
        .addr           (addr),
        .writeData      (writeData),
        .memWrite       (memWrite),
        .memType        (memType),
        .readData       (readData),
        .misaligned     (misaligned),
        .misalignedAddr (misalignedAddr),
        .toHost         (toHost),
        .toHostValid    (toHostValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Idle is an aligned doubleword load of RAM word 0: no side effects.
    task automatic idle();
        addr      = 64'h0;
        writeData = 64'h0;
        memWrite  = 1'b0;
        memType   = 3'b011;
    endtask

    task automatic do_store(input logic [63:0] a, input logic [63:0] d, input logic [2:0] t);
        addr      = a;
        writeData = d;
        memType   = t;
        memWrite  = 1'b1;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_load(input logic [63:0] a, input logic [2:0] t, output logic [63:0] d);
        addr     = a;
        memType  = t;
        memWrite = 1'b0;
        @(negedge clk);
        d = readData;
        @(posedge clk);
        #1;
        idle();
    endtask

    logic [63:0] v, v1, v2;

    initial begin
        reset = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_misaligned", 64'(misaligned), 64'h0);
        chk("rst_misaddr", misalignedAddr, 64'h0);
        chk("rst_tohost", toHost, 64'h0);
        chk("rst_tohost_valid", 64'(toHostValid), 64'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Byte lanes and sign/zero extension
        do_store(64'h40, 64'h1122334455667788, 3'b011);
        do_load(64'h47, 3'b000, v);  chk("lb_47", v, 64'h0000000000000011);
        do_load(64'h40, 3'b100, v);  chk("lbu_40", v, 64'h0000000000000088);
        do_load(64'h46, 3'b001, v);  chk("lh_46", v, 64'h0000000000001122);
        do_load(64'h40, 3'b010, v);  chk("lw_40", v, 64'h0000000055667788);
        do_load(64'h40, 3'b011, v);  chk("ld_40", v, 64'h1122334455667788);
        do_load(64'h44, 3'b101, v);  chk("lhu_44", v, 64'h0000000000003344);

        // Partial store leaves other bytes intact
        do_store(64'h80, 64'hFFFFFFFFFFFFFFFF, 3'b011);
        do_store(64'h83, 64'h0, 3'b000);
        do_load(64'h80, 3'b011, v);  chk("ld_80", v, 64'hFFFFFFFF00FFFFFF);
        do_load(64'h80, 3'b010, v);  chk("lw_80", v, 64'h0000000000FFFFFF);
        do_load(64'h80, 3'b110, v);  chk("lwu_80", v, 64'h0000000000FFFFFF);
        do_load(64'h82, 3'b000, v);  chk("lb_82", v, 64'hFFFFFFFFFFFFFFFF);
        do_store(64'h84, 64'h0000000000001234, 3'b001);
        do_load(64'h80, 3'b011, v);  chk("ld_80_sh", v, 64'hFFFF123400FFFFFF);

        // Misalignment: sticky flag, first address kept, STATUS clear
        do_store(64'h42, 64'hDEADBEEF, 3'b010);
        chk("mis_set", 64'(misaligned), 64'h1);
        chk("mis_addr", misalignedAddr, 64'h42);
        do_load(64'h40, 3'b011, v);  chk("mis_no_write", v, 64'h1122334455667788);
        do_load(64'h42, 3'b010, v);  chk("mis_load_zero", v, 64'h0);
        do_load(64'h45, 3'b001, v);  chk("mis_lh45_data", v, 64'h0);
        chk("mis_addr_kept", misalignedAddr, 64'h42);
        do_load(MB + 64'h10, 3'b011, v); chk("status_read", v, 64'h1);
        do_store(MB + 64'h12, 64'h0, 3'b011);
        chk("status_mis_noclr", 64'(misaligned), 64'h1);
        chk("status_mis_addr", misalignedAddr, 64'h42);
        do_store(MB + 64'h10, 64'h5, 3'b011);
        chk("status_clr", 64'(misaligned), 64'h0);
        chk("status_clr_addr", misalignedAddr, 64'h0);
        do_store(MB + 64'h11, 64'h0, 3'b011);
        chk("mis_status_set", 64'(misaligned), 64'h1);
        chk("mis_status_addr", misalignedAddr, MB + 64'h11);
        do_store(MB + 64'h11, 64'h0, 3'b000);
        chk("status_clr_byte", 64'(misaligned), 64'h0);

        // Reserved type: no data, no write, no flag
        do_load(64'h41, 3'b111, v);  chk("rsv_load", v, 64'h0);
        do_store(64'h40, 64'h0, 3'b111);
        chk("rsv_noflag", 64'(misaligned), 64'h0);
        do_load(64'h40, 3'b011, v);  chk("rsv_no_write", v, 64'h1122334455667788);

        // TOHOST
        do_store(MB, 64'h1, 3'b011);
        chk("tohost_val", toHost, 64'h1);
        chk("tohost_pulse", 64'(toHostValid), 64'h1);
        @(posedge clk); #1;
        chk("tohost_pulse_end", 64'(toHostValid), 64'h0);
        do_store(MB, 64'h5, 3'b010);
        chk("tohost_sw_nopulse", 64'(toHostValid), 64'h0);
        chk("tohost_sw_keep", toHost, 64'h1);
        do_load(MB, 3'b011, v);      chk("tohost_read", v, 64'h1);
        do_store(MB, 64'h7, 3'b011);
        chk("b2b_val1", toHost, 64'h7);
        chk("b2b_pulse1", 64'(toHostValid), 64'h1);
        do_store(MB, 64'h9, 3'b011);
        chk("b2b_val2", toHost, 64'h9);
        chk("b2b_pulse2", 64'(toHostValid), 64'h1);
        @(posedge clk); #1;
        chk("b2b_pulse_end", 64'(toHostValid), 64'h0);
        do_load(MB + 64'h18, 3'b011, v); chk("mmio_other", v, 64'h0);

        // Unmapped accesses
        do_store(64'h0, 64'h0, 3'b011);
        do_store(64'h2000, 64'hABCD, 3'b011);
        do_load(64'h2000, 3'b011, v); chk("unmap_read", v, 64'h0);
        do_load(64'h0, 3'b011, v);    chk("unmap_no_alias", v, 64'h0);
        chk("unmap_noflag", 64'(misaligned), 64'h0);

        // Store during reset is dropped; reset clears TOHOST
        do_store(64'h10, 64'h5555, 3'b011);
        reset = 1'b0;
        do_store(64'h10, 64'h9999, 3'b011);
        chk("rst_tohost_clr", toHost, 64'h0);
        reset = 1'b1;
        do_load(64'h10, 3'b011, v);   chk("rst_store_drop", v, 64'h5555);

        // CYCLE counter after a mid-run reset
        addr    = MB + 64'h8;
        memType = 3'b011;
        reset   = 1'b0;
        #1;
        chk("cycle_in_reset", readData, 64'h0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        v1 = readData;
        chk("cycle_after_3", v1, 64'd3);
        repeat (5) @(posedge clk);
        #1;
        v2 = readData;
        chk("cycle_after_8", v2, 64'd8);
        chk("cycle_delta5", v2 - v1, 64'd5);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
